// File: rtl/cep_dct_engine.sv
// Cepstrum DCT engine: c[k] = sum_n cof[k*mel_num+n] * mel[n] per frame, FP32 datapath.
// Define CEP_LIFTER_EN to scale each c[k] by lifter[k] before it is written.
module cep_dct_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int MEL_W      = 6,
  parameter int CEP_W      = 7,
  parameter int FRAME_W    = 7,
  parameter int MUL_LAT    = 1,
  parameter int ADD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CEP_W-1:0]         cep_num,
  input  logic [MEL_W-1:0]         mel_num,
  input  logic                     frame_clr,
  output logic                     busy,
  output logic                     done,
  output logic [MEL_W-1:0]         mel_rd_addr,
  input  logic [DATA_WIDTH-1:0]    mel_data_in,
  output logic [CEP_W+MEL_W-1:0]   cof_rd_addr,
  input  logic [DATA_WIDTH-1:0]    cof_data_in,
`ifdef CEP_LIFTER_EN
  input  logic [DATA_WIDTH-1:0]    lift_data_in,
  output logic [CEP_W-1:0]         lift_rd_addr,
`endif
  output logic                     cep_wr_en,
  output logic [FRAME_W+CEP_W-1:0] cep_wr_addr,
  output logic [DATA_WIDTH-1:0]    cep_data_out,
  output logic [FRAME_W-1:0]       frame_num
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MUL,
    S_ADD,
`ifdef CEP_LIFTER_EN
    S_LFETCH,
    S_LMUL,
`endif
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 1);
  localparam logic [7:0] ADD_LAST = 8'(ADD_LAT - 1);

  // Round-to-nearest-even packing; m carries the hidden bit at [23]. Denormals flush to zero.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                          input logic [23:0] m, input logic g, input logic st);
    logic [24:0]        r;
    logic signed [9:0]  e_r;
    logic [22:0]        frac;
    r    = {1'b0, m} + {24'd0, (g & (st | m[0]))};
    e_r  = r[24] ? e + 10'sd1 : e;
    frac = r[24] ? r[23:1] : r[22:0];
    if (e_r <= 10'sd0)   return {s, 31'd0};
    if (e_r >= 10'sd255) return {s, 8'hff, 23'd0};
    return {s, e_r[7:0], frac};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       p;
    logic signed [9:0] e;
    logic              s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)   return {s, 31'd0};
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {s, 8'hff, 23'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) return fp_pack(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    return fp_pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my;
    logic [27:0]       sum;
    logic signed [9:0] e;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    if (x[30:23] == 8'hff) return x;
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // Align the smaller operand, folding shifted-out bits into the sticky bit.
    if (d > 8'd26) my = 27'd1;
    else
      for (int i = 0; i < 26; i++)
        if (8'(i) < d) my = {1'b0, my[26:2], my[1] | my[0]};
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, my};
    else                sum = {1'b0, mx} - {1'b0, my};
    if (sum == 28'd0) return 32'd0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++)
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 10'sd1;
        end
    end
    return fp_pack(x[31], e, sum[26:3], sum[2], |sum[1:0]);
  endfunction

  state_t                   state_q, state_d;
  logic [7:0]               lat_cnt;
  logic [CEP_W-1:0]         cep_num_q, k_q;
  logic [MEL_W-1:0]         mel_num_q, n_q;
  logic [CEP_W+MEL_W-1:0]   cof_addr_q;
  logic                     mul_en, add_en, term_end, accept, degen;
  logic                     term_last, k_last;
  logic [DATA_WIDTH-1:0]    mul_a, mul_b, add_a, mul_out, acc, wr_value;
  logic [DATA_WIDTH-1:0]    mul_p [MUL_LAT];
  logic [DATA_WIDTH-1:0]    add_p [ADD_LAT];

  assign mul_out     = mul_p[MUL_LAT-1];
  assign acc         = add_p[ADD_LAT-1];
  assign term_last   = (n_q == mel_num_q - 1'b1);
  assign k_last      = (k_q == cep_num_q - 1'b1);
  assign mel_rd_addr = n_q;
  assign cof_rd_addr = cof_addr_q;
  // The accumulator is seeded with +0.0 through the adder operand at n=0 of every k.
  assign add_a       = (n_q == '0) ? '0 : acc;

`ifdef CEP_LIFTER_EN
  assign lift_rd_addr = k_q;
  assign wr_value     = mul_out;
`else
  assign wr_value     = acc;
`endif

  always_comb begin
    mul_a = mel_data_in;
    mul_b = cof_data_in;
`ifdef CEP_LIFTER_EN
    if (state_q == S_LMUL) begin
      mul_a = acc;
      mul_b = lift_data_in;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    mul_en   = 1'b0;
    add_en   = 1'b0;
    term_end = 1'b0;
    accept   = 1'b0;
    degen    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cep_num != '0 && mel_num != '0) begin
            accept  = 1'b1;
            state_d = S_FETCH;
          end else begin
            degen = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_MUL;
      S_MUL: begin
        mul_en = 1'b1;
        if (lat_cnt == MUL_LAST) state_d = S_ADD;
      end
      S_ADD: begin
        add_en = 1'b1;
        if (lat_cnt == ADD_LAST) begin
          term_end = 1'b1;
`ifdef CEP_LIFTER_EN
          state_d  = term_last ? S_LFETCH : S_FETCH;
`else
          state_d  = term_last ? S_WRITE : S_FETCH;
`endif
        end
      end
`ifdef CEP_LIFTER_EN
      S_LFETCH: state_d = S_LMUL;
      S_LMUL: begin
        mul_en = 1'b1;
        if (lat_cnt == MUL_LAST) state_d = S_WRITE;
      end
`endif
      S_WRITE: state_d = k_last ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lat_cnt      <= '0;
      cep_num_q    <= '0;
      mel_num_q    <= '0;
      k_q          <= '0;
      n_q          <= '0;
      cof_addr_q   <= '0;
      frame_num    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cep_wr_en    <= 1'b0;
      cep_wr_addr  <= '0;
      cep_data_out <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt   <= (state_d != state_q) ? 8'd0 : lat_cnt + 8'd1;
      busy      <= (state_d != S_IDLE);
      done      <= (state_q == S_DONE) | degen;
      cep_wr_en <= (state_q == S_WRITE);
      if (state_q == S_IDLE && frame_clr) frame_num <= '0;
      if (accept) begin
        cep_num_q  <= cep_num;
        mel_num_q  <= mel_num;
        k_q        <= '0;
        n_q        <= '0;
        cof_addr_q <= '0;
      end
      if (term_end) begin
        cof_addr_q <= cof_addr_q + 1'b1;
        n_q        <= term_last ? '0 : n_q + 1'b1;
      end
      if (state_q == S_WRITE) begin
        cep_wr_addr  <= {frame_num, k_q};
        cep_data_out <= wr_value;
        k_q          <= k_q + 1'b1;
      end
      if (state_q == S_DONE) frame_num <= frame_num + 1'b1;
    end
  end

  // Multiplier pipeline: advances only while mul_en, so its output holds between uses
  always_ff @(posedge clk) begin
    if (mul_en) begin
      mul_p[0] <= fp_mul(mul_a, mul_b);
      for (int i = 1; i < MUL_LAT; i++) mul_p[i] <= mul_p[i-1];
    end
  end

  // Adder pipeline: last stage is the accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ADD_LAT; i++) add_p[i] <= '0;
    end else if (add_en) begin
      add_p[0] <= fp_add(add_a, mul_out);
      for (int i = 1; i < ADD_LAT; i++) add_p[i] <= add_p[i-1];
    end
  end

endmodule
